mips_multicycle_ctrl: RTL and testbench

Sequencing controller for the multicycle variant of the MIPS CPU. It is a Moore state machine, with handshake-gated strobes, that drives a datapath with shared instruction/data memory, IR, A/B/ALUOut/MDR registers, regfile and ALU. It sequences one instruction over 3–5 states and stalls on a single-port memory through a req/ready handshake. It replaces the combinational `control` block when the multicycle datapath is built.

---
 rtl/mips_multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Sequencing controller for the multicycle MIPS datapath.
// Moore FSM: one instruction takes 3-5 states. The FETCH, MEMRD and MEMWR
// states hold on a single-port memory req/ready handshake.
//
// Handshake: a memory transfer completes on any rising edge where
// mem_req & mem_ready are both 1. mem_req (and mem_write, when set) stays
// asserted for the whole wait. mem_ready is ignored when mem_req is low.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       reg_write,
  output logic       reg_dest,
  output logic       reg_wsrc,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t r_state;
  state_t w_next;
  logic   w_mem_ready;

  // While reset is held the machine sits in FETCH. Masking ready keeps the
  // FETCH strobes (ir_write, pc_en) quiet until reset is released.
  assign w_mem_ready = mem_ready & reset_n;
  assign state       = r_state;

  // State register; reset forces FETCH immediately, even mid-instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next-state and Moore outputs (strobes gated by mem_ready / zero).
  always_comb begin
    w_next    = S_FETCH;
    mem_req   = 1'b0;
    mem_write = 1'b0;
    iord      = 1'b0;
    ir_write  = 1'b0;
    pc_en     = 1'b0;
    pc_src    = 2'b00;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    alu_ctrl  = 3'b010;
    reg_write = 1'b0;
    reg_dest  = 1'b0;
    reg_wsrc  = 1'b0;
    retire    = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = w_mem_ready;
        pc_en     = w_mem_ready;
        w_next    = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default: begin
            w_next  = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        w_next  = w_mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        reg_write = 1'b1;
        reg_wsrc  = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        retire    = w_mem_ready;
        w_next    = w_mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        case (funct)
          6'b100010: alu_ctrl = 3'b110;
          6'b100100: alu_ctrl = 3'b000;
          6'b100101: alu_ctrl = 3'b001;
          6'b101010: alu_ctrl = 3'b111;
          default:   alu_ctrl = 3'b010;
        endcase
        w_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dest  = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = 3'b110;
        pc_src    = 2'b01;
        pc_en     = zero;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        w_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
        retire = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level reference model
// produces one expected output record per cycle into a queue; a negedge
// monitor pops and compares against the DUT outputs.
module tb_mips_multicycle_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a;
  logic [2:0] alu_ctrl;
  logic       reg_write, reg_dest, reg_wsrc, retire, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_write(mem_write), .iord(iord), .ir_write(ir_write), .pc_en(pc_en),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .reg_write(reg_write), .reg_dest(reg_dest),
    .reg_wsrc(reg_wsrc), .state(state), .retire(retire), .illegal(illegal)
  );

  // ---------------- observation record ----------------
  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_write, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic       a;
    logic [1:0] b;
    logic [2:0] alu;
    logic       rw, rd, ws, ret, ill;
  } obs_t;

  logic [21:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_retire = 0, n_ir_write = 0, n_mem_write = 0, n_illegal = 0;

  function automatic obs_t observe();
    obs_t o;
    o = '{state, mem_req, mem_write, iord, ir_write, pc_en, pc_src,
          alu_src_a, alu_src_b, alu_ctrl, reg_write, reg_dest, reg_wsrc,
          retire, illegal};
    return o;
  endfunction

  function automatic obs_t idle(input logic [3:0] st);
    obs_t o;
    o     = '0;
    o.st  = st;
    o.alu = 3'b010;
    return o;
  endfunction

  task automatic compare(input string nm, input obs_t e);
    obs_t a;
    a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s @%0t: got state=%0d outs=%h, expected state=%0d outs=%h",
               nm, $time, a.st, a[17:0], e.st, e[17:0]);
    end
  endtask

  task automatic count_check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  // ---------------- monitor ----------------
  // Pops one expected record per cycle the driver issued.
  always @(negedge clk) begin
    if (reset_n) begin
      n_retire    += int'(retire);
      n_ir_write  += int'(ir_write);
      n_mem_write += int'(mem_write);
      n_illegal   += int'(illegal);
    end
    if (exp_q.size() > 0) compare("cycle", obs_t'(exp_q.pop_front()));
  end

  // ---------------- reference model / driver ----------------
  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_BEQ = 3, C_ADDI = 4,
                 C_J = 5, C_ILL = 6;

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock of stimulus: inputs applied 1 time unit after the edge.
  task automatic step(input obs_t e, input logic mr, input logic z);
    mem_ready = mr;
    zero      = z;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input int fw);
    obs_t e;
    e = idle(4'd0); e.mem_req = 1'b1; e.b = 2'b01;
    for (int i = 0; i < fw; i++) step(e, 1'b0, rbit());
    e.ir_write = 1'b1; e.pc_en = 1'b1;
    step(e, 1'b1, rbit());
  endtask

  task automatic do_decode(input logic [5:0] op);
    obs_t e;
    e = idle(4'd1); e.b = 2'b11;
    e.ill = (classify(op) == C_ILL);
    step(e, rbit(), rbit());
  endtask

  task automatic do_memadr();
    obs_t e;
    e = idle(4'd2); e.a = 1'b1; e.b = 2'b10;
    step(e, rbit(), rbit());
  endtask

  // zsel: 0/1 forces zero in BRANCH, anything else randomizes it.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input int zsel);
    obs_t e;
    logic z;
    opcode = op;
    funct  = fn;
    do_fetch(fw);
    do_decode(op);
    case (classify(op))
      C_LW: begin
        do_memadr();
        e = idle(4'd3); e.mem_req = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) step(e, 1'b0, rbit());
        step(e, 1'b1, rbit());
        e = idle(4'd4); e.rw = 1'b1; e.ws = 1'b1; e.ret = 1'b1;
        step(e, rbit(), rbit());
      end
      C_SW: begin
        do_memadr();
        e = idle(4'd5); e.mem_req = 1'b1; e.mem_write = 1'b1; e.iord = 1'b1;
        for (int i = 0; i < mw; i++) step(e, 1'b0, rbit());
        e.ret = 1'b1;
        step(e, 1'b1, rbit());
      end
      C_R: begin
        e = idle(4'd6); e.a = 1'b1; e.alu = alu_of(fn);
        step(e, rbit(), rbit());
        e = idle(4'd7); e.rw = 1'b1; e.rd = 1'b1; e.ret = 1'b1;
        step(e, rbit(), rbit());
      end
      C_BEQ: begin
        z = (zsel == 0) ? 1'b0 : (zsel == 1) ? 1'b1 : rbit();
        e = idle(4'd8); e.a = 1'b1; e.alu = 3'b110; e.pc_src = 2'b01;
        e.pc_en = z; e.ret = 1'b1;
        step(e, rbit(), z);
      end
      C_ADDI: begin
        e = idle(4'd9); e.a = 1'b1; e.b = 2'b10;
        step(e, rbit(), rbit());
        e = idle(4'd10); e.rw = 1'b1; e.ret = 1'b1;
        step(e, rbit(), rbit());
      end
      C_J: begin
        e = idle(4'd11); e.pc_src = 2'b10; e.pc_en = 1'b1; e.ret = 1'b1;
        step(e, rbit(), rbit());
      end
      default: ;
    endcase
  endtask

  // ---------------- test sequence ----------------
  logic [5:0] op_pool [7];
  logic [5:0] fn_pool [6];
  obs_t       rst_exp;
  int         base, base2;

  initial begin
    op_pool = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000,
                6'b000010, 6'b111111};
    fn_pool = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                6'b000000};
    rst_exp = idle(4'd0); rst_exp.mem_req = 1'b1; rst_exp.b = 2'b01;

    reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
    opcode = 6'b100011; funct = 6'b0;
    #3 compare("reset_state", rst_exp);
    @(posedge clk); @(posedge clk); #2;
    compare("reset_hold", rst_exp);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Zero-wait program: lw; sw; add; beq taken; j.
    base = n_retire;
    run_instr(6'b100011, 6'b000000, 0, 0, 2);
    run_instr(6'b101011, 6'b000000, 0, 0, 2);
    run_instr(6'b000000, 6'b100000, 0, 0, 2);
    run_instr(6'b000100, 6'b000000, 0, 0, 1);
    run_instr(6'b000010, 6'b000000, 0, 0, 2);
    count_check("program_retires", n_retire - base, 5);

    // beq not taken.
    base = n_retire;
    run_instr(6'b000100, 6'b000000, 0, 0, 0);
    count_check("beq_nt_retire", n_retire - base, 1);

    // sw with 3 fetch waits and 2 store waits.
    base  = n_ir_write;
    base2 = n_mem_write;
    run_instr(6'b101011, 6'b000000, 3, 2, 2);
    count_check("sw_wait_ir_write", n_ir_write - base, 1);
    count_check("sw_wait_mem_write_cycles", n_mem_write - base2, 3);

    // Illegal opcode.
    base  = n_illegal;
    base2 = n_retire;
    run_instr(6'b111111, 6'b000000, 0, 0, 2);
    count_check("illegal_pulses", n_illegal - base, 1);
    count_check("illegal_no_retire", n_retire - base2, 0);

    // Funct sweep including unsupported 000000.
    for (int i = 0; i < 6; i++) run_instr(6'b000000, fn_pool[i], 0, 0, 2);

    // Reset mid-instruction while waiting in MEMRD.
    opcode = 6'b100011;
    do_fetch(0);
    do_decode(6'b100011);
    do_memadr();
    rst_exp = idle(4'd3); rst_exp.mem_req = 1'b1; rst_exp.iord = 1'b1;
    step(rst_exp, 1'b0, 1'b0);
    mem_ready = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    rst_exp = idle(4'd0); rst_exp.mem_req = 1'b1; rst_exp.b = 2'b01;
    compare("midreset_async", rst_exp);
    @(posedge clk); #2;
    compare("midreset_hold", rst_exp);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Randomized instruction stream.
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 7) == 7) ? 6'($urandom) : op_pool[$urandom_range(0, 6)];
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
      run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 2);
    end

    @(negedge clk);
    count_check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
